// File: rtl/matvec_seq.sv
// matvec_seq: sequencer for a matrix-vector product on an external MAC.
// For each row it clears the accumulator, issues one operand beat per
// column, waits LAT cycles for the MAC result to settle, and presents the
// row sum on a valid/ready result port. All outputs are registered.
module matvec_seq #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  rows,
  input  logic [4:0]  cols,
  input  logic [15:0] mac_f,
  input  logic        res_ready,
  output logic        busy,
  output logic        done,
  output logic        mac_clr,
  output logic        mac_en,
  output logic [7:0]  mat_addr,
  output logic [3:0]  vec_addr,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic [3:0]  res_row
);

  // Drain counter must be able to hold the value LAT itself.
  localparam int DW = (LAT < 2) ? 1 : $clog2(LAT + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ISSUE  = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  // Dimensions above 16 are clamped to the 16x16 array size.
  function automatic logic [4:0] sat16(input logic [4:0] v);
    logic [4:0] r;
    if (v > 5'd16) begin
      r = 5'd16;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t          state_r, state_s;
  logic [4:0]      rows_l_r, rows_l_s;
  logic [4:0]      cols_l_r, cols_l_s;
  logic [3:0]      row_r, row_s;
  logic [3:0]      col_r, col_s;
  logic [7:0]      base_r, base_s;      // row_r * cols_l_r, kept incrementally
  logic [DW-1:0]   drain_r, drain_s;

  logic            busy_s, done_s, mac_clr_s, mac_en_s, res_valid_s;
  logic [7:0]      mat_addr_s;
  logic [3:0]      vec_addr_s;
  logic [15:0]     res_data_s;
  logic [3:0]      res_row_s;
  logic            col_last_s, row_last_s;

  assign col_last_s = ({1'b0, col_r} == (cols_l_r - 5'd1));
  assign row_last_s = ({1'b0, row_r} == (rows_l_r - 5'd1));

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    state_s     = state_r;
    rows_l_s    = rows_l_r;
    cols_l_s    = cols_l_r;
    row_s       = row_r;
    col_s       = col_r;
    base_s      = base_r;
    drain_s     = drain_r;
    done_s      = 1'b0;
    mac_clr_s   = 1'b0;
    mac_en_s    = 1'b0;
    mat_addr_s  = mat_addr;
    vec_addr_s  = vec_addr;
    res_valid_s = 1'b0;
    res_data_s  = res_data;
    res_row_s   = res_row;

    case (state_r)
      IDLE: begin
        if (start) begin
          if ((rows != 5'd0) && (cols != 5'd0)) begin
            rows_l_s  = sat16(rows);
            cols_l_s  = sat16(cols);
            row_s     = 4'd0;
            col_s     = 4'd0;
            base_s    = 8'd0;
            mac_clr_s = 1'b1;
            state_s   = CLEAR;
          end else begin
            // Empty product: complete immediately without touching the MAC.
            done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        // First beat of the row goes out on the next cycle.
        col_s      = 4'd0;
        mac_en_s   = 1'b1;
        mat_addr_s = base_r;
        vec_addr_s = 4'd0;
        state_s    = ISSUE;
      end
      ISSUE: begin
        if (col_last_s) begin
          drain_s = DW'(1);
          state_s = DRAIN;
        end else begin
          col_s      = col_r + 4'd1;
          mac_en_s   = 1'b1;
          mat_addr_s = base_r + {4'd0, col_r + 4'd1};
          vec_addr_s = col_r + 4'd1;
        end
      end
      DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          drain_s     = '0;
          res_data_s  = mac_f;
          res_row_s   = row_r;
          res_valid_s = 1'b1;
          state_s     = OUTPUT;
        end else begin
          drain_s = drain_r + DW'(1);
        end
      end
      OUTPUT: begin
        if (res_ready) begin
          if (row_last_s) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            row_s     = row_r + 4'd1;
            col_s     = 4'd0;
            base_s    = base_r + {3'd0, cols_l_r};
            mac_clr_s = 1'b1;
            state_s   = CLEAR;
          end
        end else begin
          res_valid_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State, context and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      rows_l_r  <= 5'd0;
      cols_l_r  <= 5'd0;
      row_r     <= 4'd0;
      col_r     <= 4'd0;
      base_r    <= 8'd0;
      drain_r   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      mat_addr  <= 8'd0;
      vec_addr  <= 4'd0;
      res_valid <= 1'b0;
      res_data  <= 16'd0;
      res_row   <= 4'd0;
    end else begin
      state_r   <= state_s;
      rows_l_r  <= rows_l_s;
      cols_l_r  <= cols_l_s;
      row_r     <= row_s;
      col_r     <= col_s;
      base_r    <= base_s;
      drain_r   <= drain_s;
      busy      <= busy_s;
      done      <= done_s;
      mac_clr   <= mac_clr_s;
      mac_en    <= mac_en_s;
      mat_addr  <= mat_addr_s;
      vec_addr  <= vec_addr_s;
      res_valid <= res_valid_s;
      res_data  <= res_data_s;
      res_row   <= res_row_s;
    end
  end

endmodule
